// File: rtl/rps_draw_sequencer.sv
// rps_draw_sequencer
//   Draws one rock-paper-scissors frame on a 160x120 vga_adapter. The computer's
//   80x120 hand image goes in the left half and the user's goes in the right half.
//   The block outputs one pixel per clock. Each image ROM returns its data one
//   cycle after the address, so x/y/plot are delayed by one stage to line up
//   with that data.
//
// Ports
//   CLOCK_50  in   1   system clock, rising edge
//   reset_n   in   1   asynchronous active-low reset
//   start     in   1   draw request, sampled only while idle
//   choice_c  in   2   computer choice: 00 rock, 01 scissor, 1x paper
//   choice_u  in   2   user choice, same encoding
//   rom_addr  out  15  shared ROM address, row*IMG_W + col (combinational)
//   q_r/q_s/q_p in 1   rock / scissor / paper ROM data, 1-cycle latency
//   x         out  8   pixel x, registered
//   y         out  7   pixel y, registered
//   colour    out  3   pixel colour, from selected ROM bit and in-flight panel
//   plot      out  1   pixel write enable, registered
//   busy      out  1   high from accepted start until the last pixel is plotted
//   done      out  1   one-cycle pulse after the last pixel
module rps_draw_sequencer #(
  parameter int unsigned IMG_W   = 80,
  parameter int unsigned IMG_H   = 120,
  parameter int unsigned X_OFF_U = 80,
  parameter logic [2:0]  FG      = 3'b010,
  parameter logic [2:0]  BG_C    = 3'b111,
  parameter logic [2:0]  BG_U    = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        start,
  input  logic [1:0]  choice_c,
  input  logic [1:0]  choice_u,
  output logic [14:0] rom_addr,
  input  logic        q_r,
  input  logic        q_s,
  input  logic        q_p,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAW_C = 2'd1,
    DRAW_U = 2'd2,
    FLUSH  = 2'd3
  } state_t;

  localparam logic [6:0]  COL_LAST = 7'(IMG_W - 1);
  localparam logic [6:0]  ROW_LAST = 7'(IMG_H - 1);
  localparam logic [7:0]  X_OFF8   = 8'(X_OFF_U);
  localparam logic [14:0] IMG_W15  = 15'(IMG_W);

  state_t      state_r;
  logic [6:0]  col_r;
  logic [6:0]  row_r;
  logic [1:0]  ch_c_r;
  logic [1:0]  ch_u_r;
  logic [7:0]  x_r;
  logic [6:0]  y_r;
  logic        plot_r;
  logic        busy_r;
  logic        done_r;
  logic        panel_r;   // panel of the pixel whose ROM data is arriving now: 1 = user
  logic        drawing_s;
  logic        draw_u_s;
  logic [1:0]  sel_choice_s;
  logic        q_sel_s;

  // Maps a ROM bit to a colour. A 0 bit is the hand. A 1 bit is the background,
  // and the background colour depends on the panel.
  function automatic logic [2:0] map_colour(input logic q, input logic panel);
    logic [2:0] c;
    if (q == 1'b0) begin
      c = FG;
    end else if (panel == 1'b1) begin
      c = BG_U;
    end else begin
      c = BG_C;
    end
    return c;
  endfunction

  assign drawing_s = (state_r == DRAW_C) || (state_r == DRAW_U);
  assign draw_u_s  = (state_r == DRAW_U);

  // ROM address from the counters. Both counters are zero outside the draw states.
  assign rom_addr = ({8'd0, row_r} * IMG_W15) + {8'd0, col_r};

  // Sequencer FSM, pixel counters, choice latches and the one-stage output pipeline
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
      col_r   <= 7'd0;
      row_r   <= 7'd0;
      ch_c_r  <= 2'b00;
      ch_u_r  <= 2'b00;
      x_r     <= 8'd0;
      y_r     <= 7'd0;
      plot_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      panel_r <= 1'b0;
    end else begin
      // This stage lines up with the ROM data for the current address
      plot_r  <= drawing_s;
      x_r     <= draw_u_s ? ({1'b0, col_r} + X_OFF8) : {1'b0, col_r};
      y_r     <= row_r;
      panel_r <= draw_u_s;
      done_r  <= (state_r == FLUSH);

      case (state_r)
        IDLE: begin
          if (start) begin
            ch_c_r  <= choice_c;
            ch_u_r  <= choice_u;
            col_r   <= 7'd0;
            row_r   <= 7'd0;
            busy_r  <= 1'b1;
            state_r <= DRAW_C;
          end else begin
            busy_r  <= 1'b0;
          end
        end
        DRAW_C, DRAW_U: begin
          if (col_r == COL_LAST) begin
            col_r <= 7'd0;
            if (row_r == ROW_LAST) begin
              row_r   <= 7'd0;
              // The user panel follows directly, with no gap cycle
              state_r <= (state_r == DRAW_C) ? DRAW_U : FLUSH;
            end else begin
              row_r <= row_r + 7'd1;
            end
          end else begin
            col_r <= col_r + 7'd1;
          end
        end
        FLUSH: begin
          // The last pixel is being plotted this cycle
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Selects the ROM using the latched choice of the panel now in flight
  always_comb begin
    sel_choice_s = panel_r ? ch_u_r : ch_c_r;
    case (sel_choice_s)
      2'b00:   q_sel_s = q_r;
      2'b01:   q_sel_s = q_s;
      default: q_sel_s = q_p;
    endcase
  end

  assign colour = map_colour(q_sel_s, panel_r);
  assign x      = x_r;
  assign y      = y_r;
  assign plot   = plot_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_rps_draw_sequencer.sv
module tb_rps_draw_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [1:0]  choice_c;
  logic [1:0]  choice_u;
  logic [14:0] rom_addr;
  logic        q_r, q_s, q_p;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        plot, busy, done;

  int checks = 0;
  int passed = 0;
  int rom_mode = 0;   // 0 pattern, 1 all ones, 2 all zeros

  rps_draw_sequencer dut (
    .CLOCK_50(clk), .reset_n(reset_n), .start(start),
    .choice_c(choice_c), .choice_u(choice_u), .rom_addr(rom_addr),
    .q_r(q_r), .q_s(q_s), .q_p(q_p),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // ROM models with one-cycle latency. The rock and scissor contents are
  // complementary, so selecting the wrong ROM changes the colour of every pixel.
  always @(posedge clk) begin
    q_r <= (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? 1'b0 :  rom_addr[0];
    q_s <= (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? 1'b0 : ~rom_addr[0];
    q_p <= (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? 1'b0 :  rom_addr[1];
  end

  function automatic logic [2:0] exp_colour(input int mode, input logic [1:0] ch,
                                            input bit user, input int addr);
    logic [14:0] a;
    logic q;
    a = addr[14:0];
    if (mode == 1) q = 1'b1;
    else if (mode == 2) q = 1'b0;
    else if (ch == 2'b00) q = a[0];
    else if (ch == 2'b01) q = ~a[0];
    else q = a[1];
    if (q == 1'b0) return 3'b010;
    return user ? 3'b000 : 3'b111;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Drives a one-cycle start request. Returns just after the sampling edge E0.
  task automatic start_frame(input logic [1:0] cc, input logic [1:0] cu);
    @(negedge clk);
    choice_c = cc;
    choice_u = cu;
    start = 1'b1;
    @(posedge clk);
  endtask

  // Checks the frame one negedge at a time, for k = 0..19201 cycles after E0.
  // The caller must have just passed E0.
  task automatic check_frame(input logic [1:0] cc, input logic [1:0] cu,
                             input bit hold, input bit mid,
                             output logic [2:0] c0, output logic [2:0] u0);
    int plots, seq_err, col_err, ctl_err, idx, p, ex, ey;
    logic [14:0] ea;
    bit e_plot, e_busy, e_done;
    plots = 0; seq_err = 0; col_err = 0; ctl_err = 0;
    c0 = 3'b101; u0 = 3'b101;
    for (int k = 0; k <= 19201; k++) begin
      @(negedge clk);
      if (k == 0 && !hold) start = 1'b0;
      if (mid) begin
        if (k == 99 || k == 14999) start = 1'b1;
        if (k == 100 || k == 15000) start = 1'b0;
        if (k == 4999) begin choice_c = ~cc; choice_u = ~cu; end
      end
      e_plot = (k >= 1) && (k <= 19200);
      e_busy = (k <= 19200);
      e_done = (k == 19201);
      if (plot !== e_plot || busy !== e_busy || done !== e_done) ctl_err++;
      if (k <= 19199) begin
        ea = (k < 9600) ? 15'(k) : 15'(k - 9600);
        if (rom_addr !== ea) seq_err++;
      end
      if (plot === 1'b1) begin
        idx = plots;
        p   = idx % 9600;
        ex  = ((idx < 9600) ? 0 : 80) + p % 80;
        ey  = p / 80;
        if (x !== 8'(ex) || y !== 7'(ey)) seq_err++;
        if (colour !== exp_colour(rom_mode, (idx < 9600) ? cc : cu, idx >= 9600, p)) col_err++;
        if (idx == 0) c0 = colour;
        if (idx == 9600) u0 = colour;
        plots++;
      end
    end
    chk("plot_count", plots, 19200);
    chk("addr_xy_sequence_errors", seq_err, 0);
    chk("colour_errors", col_err, 0);
    chk("plot_busy_done_timing_errors", ctl_err, 0);
  endtask

  // Confirms that nothing is issued while start stays low
  task automatic check_idle(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) seen++;
    end
    chk(name, seen, 0);
  endtask

  typedef struct {
    logic [1:0] cc;
    logic [1:0] cu;
    int         mode;
    bit         hold;     // keep start high so the next entry follows back-to-back
    bit         mid;      // stray starts at E100/E15000, choice change at E5000
    logic [2:0] exp_c0;   // colour of the first left-panel pixel
    logic [2:0] exp_u0;   // colour of the first right-panel pixel
  } vec_t;

  vec_t tbl[3];
  logic [2:0] c0, u0;

  initial begin
    // Entry 0: rock on the left and scissor on the right. Address 0 gives rock 0 -> FG and scissor 1 -> BG_U.
    tbl[0] = '{cc: 2'b00, cu: 2'b01, mode: 0, hold: 1'b1, mid: 1'b0, exp_c0: 3'b010, exp_u0: 3'b000};
    // Entry 1: follows entry 0 back-to-back with an all-ones ROM.
    tbl[1] = '{cc: 2'b00, cu: 2'b01, mode: 1, hold: 1'b0, mid: 1'b0, exp_c0: 3'b111, exp_u0: 3'b000};
    // Entry 2: paper on both panels (11 and 10). Address 0 bit1 = 0 -> FG.
    tbl[2] = '{cc: 2'b11, cu: 2'b10, mode: 0, hold: 1'b0, mid: 1'b1, exp_c0: 3'b010, exp_u0: 3'b010};

    // Reset asserted while start is high
    reset_n = 1'b0; start = 1'b1; choice_c = 2'b10; choice_u = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_plot", int'(plot), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_x", int'(x), 0);
    chk("reset_y", int'(y), 0);
    chk("reset_rom_addr", int'(rom_addr), 0);
    start = 1'b0;
    reset_n = 1'b1;
    check_idle("idle_after_reset", 10);

    // Table-driven frames
    for (int i = 0; i < 3; i++) begin
      rom_mode = tbl[i].mode;
      if (i == 0 || !tbl[i-1].hold) begin
        start_frame(tbl[i].cc, tbl[i].cu);
      end else begin
        // start is still high, so the next edge (E19202) starts this frame
        choice_c = tbl[i].cc;
        choice_u = tbl[i].cu;
        @(posedge clk);
      end
      check_frame(tbl[i].cc, tbl[i].cu, tbl[i].hold, tbl[i].mid, c0, u0);
      chk($sformatf("first_left_colour_%0d", i), int'(c0), int'(tbl[i].exp_c0));
      chk($sformatf("first_right_colour_%0d", i), int'(u0), int'(tbl[i].exp_u0));
      if (!tbl[i].hold) check_idle($sformatf("no_retrigger_%0d", i), 4);
    end

    // Reset asserted mid-draw at E9000, then a fresh frame with new choices
    rom_mode = 0;
    start_frame(2'b00, 2'b01);
    for (int k = 0; k < 9000; k++) begin
      @(negedge clk);
      if (k == 0) start = 1'b0;
    end
    chk("plot_before_abort", int'(plot), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_plot", int'(plot), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_xy", int'({x, y}), 0);
    chk("abort_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    reset_n = 1'b1;
    check_idle("idle_after_abort", 3);
    rom_mode = 2;
    start_frame(2'b01, 2'b00);
    check_frame(2'b01, 2'b00, 1'b0, 1'b0, c0, u0);
    chk("zeros_left_colour", int'(c0), 2);
    chk("zeros_right_colour", int'(u0), 2);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
